// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operand width,
// iteration counter sizing, op encodings and the sequencer state type.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // MULT and DIV are the signed flavours; the unsigned ones have op[0] set.
  function automatic logic op_is_signed(logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute-stage request/result bundle for hilo_muldiv.
//   master: start, op, a, b  ->   (pipeline side)
//   slave : busy, done, div_by_zero, hi, lo  -> (unit side)
interface hilo_muldiv_if;
  import muldiv_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : {upper, lower} accumulator; lower half holds multiplier or
//              dividend bits still to be consumed / quotient bits produced
//   opd      : multiplicand or divisor magnitude
//   acc_next : accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_top;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    // Multiply: add on the current LSB of the multiplier, then shift the
    // whole accumulator right, carry included.
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    // Divide: shift left one bit; the partial remainder needs WIDTH+1 bits
    // before the compare since its top bit can be set transiently.
    div_top = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge  = div_top >= {1'b0, opd};
    div_rem = div_ge ? (div_top[WIDTH-1:0] - opd) : div_top[WIDTH-1:0];
    acc_next = is_div ? {div_rem, acc[WIDTH-2:0], div_ge}
                      : {mul_sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of hilo_muldiv_if (start/op/a/b in,
//              busy/done/div_by_zero/hi/lo out, all registered)
//
// state | meaning
// IDLE  | accept start; MTHI/MTLO write HI/LO immediately
// RUN   | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | sign-correct, write HI/LO, pulse done
module hilo_muldiv
  import muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  hilo_muldiv_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign sign_a = op_is_signed(bus.op) & bus.a[WIDTH-1];
  assign sign_b = op_is_signed(bus.op) & bus.b[WIDTH-1];
  assign mag_a  = sign_a ? -bus.a : bus.a;
  assign mag_b  = sign_b ? -bus.b : bus.b;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  muldiv_step u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opd      (opd_q),
    .acc_next (step_acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opd_d      = opd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    a_raw_d    = a_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d    = RUN;
              busy_d     = 1'b1;
              cnt_d      = '0;
              is_div_d   = bus.op[1];
              neg_res_d  = sign_a ^ sign_b;
              neg_rem_d  = sign_a;
              dbz_pend_d = bus.op[1] & (bus.b == '0);
              a_raw_d    = bus.a;
              // Upper half starts clear; lower half holds the bits the
              // iterations consume (multiplier or dividend).
              opd_d      = bus.op[1] ? mag_b : mag_a;
              acc_d      = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dbz_pend_q) begin
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      a_raw_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opd_q      <= opd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      a_raw_q    <= a_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: expected HI/LO/div_by_zero are pushed
// onto a scoreboard queue when an op is issued and popped when done pulses.
module tb_hilo_muldiv;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hilo_muldiv_if bus();

  hilo_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference results from 64-bit simulator arithmetic.
  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    exp_t        r;
    longint      sa, sb_v, q, m;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    r    = '0;
    case (op)
      3'b000: begin p = sa * sb_v; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'b001: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (op == 3'b010) begin
          q = sa / sb_v; m = sa % sb_v;
          p = q; r.lo = p[31:0];
          p = m; r.hi = p[31:0];
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom();
    bus.b = $urandom();
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    logic [2:0]  ops[5];
    logic [31:0] as[5], bs[5];
    exp_t        e;
    int          lat;
    ops[0] = OP_MULT;  as[0] = 32'hFFFF_FFFE; bs[0] = 32'h3;
    ops[1] = OP_MULTU; as[1] = 32'hFFFF_FFFE; bs[1] = 32'h3;
    for (int i = 2; i < 5; i++) begin
      ops[i] = (i % 2 == 0) ? OP_MULT : OP_MULTU;
      as[i] = $urandom(); bs[i] = $urandom();
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA, dbz: 1'b0});
      else if (i == 1) sb.push_back('{hi: 32'h0000_0002, lo: 32'hFFFF_FFFA, dbz: 1'b0});
      else             sb.push_back(model(ops[i], as[i], bs[i]));
      issue(ops[i], as[i], bs[i]);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy[%0d] got=%b exp=1", i, bus.busy); end
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency[%0d] got=%0d exp=33", i, lat); end
      checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL mult_hi[%0d] got=%h exp=%h", i, bus.hi, e.hi); end
      checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL mult_lo[%0d] got=%h exp=%h", i, bus.lo, e.lo); end
      checks++; if (bus.div_by_zero !== e.dbz) begin errors++; $display("FAIL mult_dbz[%0d] got=%b exp=%b", i, bus.div_by_zero, e.dbz); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mult_done_pulse[%0d] got done=%b busy=%b exp 0/0", i, bus.done, bus.busy); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[7];
    logic [31:0] as[7], bs[7];
    exp_t        e;
    int          lat;
    ops[0] = OP_DIV;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'h2;
    ops[1] = OP_DIVU; as[1] = 32'h7;         bs[1] = 32'h2;
    ops[2] = OP_DIV;  as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF;
    ops[3] = OP_DIVU; as[3] = 32'h1234;      bs[3] = 32'h0;
    ops[4] = OP_DIV;  as[4] = 32'hF000_0001; bs[4] = 32'h0;
    ops[5] = OP_DIV;  as[5] = $urandom();    bs[5] = $urandom_range(1, 32'h7FFF) | 32'hFFFF_8000;
    ops[6] = OP_DIVU; as[6] = $urandom();    bs[6] = $urandom_range(1, 32'hFFFF);
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0});
        1: sb.push_back('{hi: 32'h1,         lo: 32'h3,         dbz: 1'b0});
        2: sb.push_back('{hi: 32'h0,         lo: 32'h8000_0000, dbz: 1'b0});
        3: sb.push_back('{hi: 32'h1234,      lo: 32'hFFFF_FFFF, dbz: 1'b1});
        4: sb.push_back('{hi: 32'hF000_0001, lo: 32'hFFFF_FFFF, dbz: 1'b1});
        default: sb.push_back(model(ops[i], as[i], bs[i]));
      endcase
      issue(ops[i], as[i], bs[i]);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat != 33) begin errors++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
      checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL div_hi[%0d] got=%h exp=%h", i, bus.hi, e.hi); end
      checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL div_lo[%0d] got=%h exp=%h", i, bus.lo, e.lo); end
      checks++; if (bus.div_by_zero !== e.dbz) begin errors++; $display("FAIL div_dbz[%0d] got=%b exp=%b", i, bus.div_by_zero, e.dbz); end
      @(negedge clk);
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dbz_clear[%0d] got=%b exp=0", i, bus.div_by_zero); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    logic [31:0] a2, b2;
    a2 = $urandom(); b2 = $urandom_range(1, 32'hFFFF);
    sb.push_back('{hi: 32'h1, lo: 32'h0001_0000, dbz: 1'b0});
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'h0001_0000; bus.b = 32'h0001_0001;
    @(posedge clk);
    @(negedge clk);
    // start stays high with new operands for the whole run
    bus.op = OP_DIVU; bus.a = a2; bus.b = b2;
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=33", lat); end
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL b2b_first_hi got=%h exp=%h", bus.hi, e.hi); end
    checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL b2b_first_lo got=%h exp=%h", bus.lo, e.lo); end
    sb.push_back(model(OP_DIVU, a2, b2));
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_e34 got busy=%b exp=1", bus.busy); end
    bus.start = 1'b0;
    bus.a = $urandom(); bus.b = $urandom();
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL b2b_second_hi got=%h exp=%h", bus.hi, e.hi); end
    checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL b2b_second_lo got=%h exp=%h", bus.lo, e.lo); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got=%h exp=deadbeef", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", bus.busy); end
    bus.op = OP_MTLO; bus.a = 32'h5;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.lo !== 32'h5) begin errors++; $display("FAIL mtlo_lo got=%h exp=5", bus.lo); end
    checks++; if (bus.hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_hi_hold got=%h exp=deadbeef", bus.hi); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
    bus.op = 3'b110; bus.a = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    bus.op = 3'b111;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h5) begin errors++; $display("FAIL reserved_op got hi=%h lo=%h exp deadbeef/5", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reserved_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    bit   saw_done;
    issue(OP_MULT, 32'h1234_5678, 32'h9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got hi=%h lo=%h exp 0/0", bus.hi, bus.lo); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_stale_done got=1 exp=0"); end
    sb.push_back('{hi: 32'h0, lo: 32'd42, dbz: 1'b0});
    issue(OP_MULT, 32'd6, 32'd7);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (lat != 33) begin errors++; $display("FAIL rstmid_latency got=%0d exp=33", lat); end
    checks++; if (bus.hi !== e.hi) begin errors++; $display("FAIL rstmid_hi got=%h exp=%h", bus.hi, e.hi); end
    checks++; if (bus.lo !== e.lo) begin errors++; $display("FAIL rstmid_lo got=%h exp=%h", bus.lo, e.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
